// File: rtl/wbdispatch.sv
// wbdispatch
//   Wishbone classic router from a single master to NUM_SLAVES register slaves.
//   The slave index comes from the top SEL_W address bits. It is decoded into a
//   registered one-hot strobe. The addressed slave's read data and ack are muxed
//   back to the master. An index with no slave behind it gets an error response.
//
//   Optional feature macro: WBDISPATCH_TIMEOUT_EN
//     defined   - a 10-bit counter aborts a transaction to a silent slave after
//                 TIMEOUT busy cycles and returns an error response.
//     undefined - a busy transaction waits until the slave acks or the master
//                 aborts.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   wb_stb_i   master strobe
//   wb_cyc_i   master cycle; dropping it while busy aborts the transaction
//   wb_we_i    master write enable
//   wb_adr_i   master address (top SEL_W bits select the slave)
//   wb_dat_i   master write data
//   wb_dat_o   read data to master (ERR_DATA on error responses)
//   wb_ack_o   one-cycle ack to master
//   wb_err_o   pulses together with wb_ack_o on error responses
//   s_stb_o    per-slave strobe, one-hot or zero
//   s_cyc_o    per-slave cycle, identical to s_stb_o
//   s_we_o     latched write enable, broadcast to all slaves
//   s_adr_o    latched slave-local address, broadcast to all slaves
//   s_dat_o    latched write data, broadcast to all slaves
//   s_dat_i    packed slave read data, slave k at [k*DATA_W +: DATA_W]
//   s_ack_i    per-slave acks
module wbdispatch #(
    parameter int                NUM_SLAVES = 7,
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter int                SEL_W      = 8,
    parameter int                TIMEOUT    = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA   = {DATA_W{1'b1}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_stb_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_we_i,
    input  logic [ADDR_W-1:0]            wb_adr_i,
    input  logic [DATA_W-1:0]            wb_dat_i,
    output logic [DATA_W-1:0]            wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic [NUM_SLAVES-1:0]        s_stb_o,
    output logic [NUM_SLAVES-1:0]        s_cyc_o,
    output logic                         s_we_o,
    output logic [ADDR_W-SEL_W-1:0]      s_adr_o,
    output logic [DATA_W-1:0]            s_dat_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // One extra bit so that NUM_SLAVES == 2**SEL_W still fits in the compare.
    localparam logic [SEL_W:0]          NUM_S    = (SEL_W+1)'(NUM_SLAVES);
    localparam logic [NUM_SLAVES-1:0]   STB_ONE  = NUM_SLAVES'(1);
    localparam logic [9:0]              TMO_LIM  = 10'(TIMEOUT);

    logic [1:0]       state;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] adr_idx;
    logic             accept;
    logic             mapped;
    logic [DATA_W-1:0] sel_dat;
    logic             sel_ack;
    logic             tmo_hit;

    assign adr_idx = wb_adr_i[ADDR_W-1 -: SEL_W];
    // The ack term keeps a strobe that is still high on the ack cycle from
    // being taken as a new request.
    assign accept  = (state == ST_IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign mapped  = {1'b0, adr_idx} < NUM_S;
    assign s_cyc_o = s_stb_o;

    // Response mux: only the latched slave's data and ack are visible, so acks
    // from any other slave are ignored.
    always_comb begin
        sel_dat = '0;
        sel_ack = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == SEL_W'(k)) begin
                sel_dat = s_dat_i[k*DATA_W +: DATA_W];
                sel_ack = s_ack_i[k];
            end
        end
    end

`ifdef WBDISPATCH_TIMEOUT_EN
    logic [9:0] tmo_cnt;

    // The counter holds the number of busy cycles already elapsed. The error
    // response fires on the edge where the count reaches TMO_LIM, so the strobe
    // stays high for exactly TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == ST_BUSY) begin
            tmo_cnt <= tmo_cnt + 10'd1;
        end
    end

    assign tmo_hit = (tmo_cnt + 10'd1) == TMO_LIM;
`else
    // No counter in this build. The limit is still elaborated so that both
    // builds accept the same parameter set.
    assign tmo_hit = 1'b0 && (TMO_LIM != '0);
`endif

    // Main transaction FSM. Inside BUSY the priority is: master abort, then
    // slave ack, then timeout. An ack that arrives in the same cycle as the
    // abort is therefore dropped, and an ack that arrives in the timeout cycle
    // still completes normally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            idx_q    <= '0;
            s_stb_o  <= '0;
            s_we_o   <= 1'b0;
            s_adr_o  <= '0;
            s_dat_o  <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        idx_q   <= adr_idx;
                        s_we_o  <= wb_we_i;
                        s_adr_o <= wb_adr_i[ADDR_W-SEL_W-1:0];
                        s_dat_o <= wb_dat_i;
                        if (mapped) begin
                            s_stb_o <= STB_ONE << adr_idx;
                            state   <= ST_BUSY;
                        end else begin
                            wb_ack_o <= 1'b1;
                            wb_err_o <= 1'b1;
                            wb_dat_o <= ERR_DATA;
                            state    <= ST_ERR;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!wb_cyc_i) begin
                        s_stb_o <= '0;
                        state   <= ST_IDLE;
                    end else if (sel_ack) begin
                        s_stb_o  <= '0;
                        wb_dat_o <= sel_dat;
                        wb_ack_o <= 1'b1;
                        state    <= ST_DONE;
                    end else if (tmo_hit) begin
                        s_stb_o  <= '0;
                        wb_dat_o <= ERR_DATA;
                        wb_ack_o <= 1'b1;
                        wb_err_o <= 1'b1;
                        state    <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbdispatch.sv
// tb_wbdispatch
//   Scoreboard bench for wbdispatch with seven slaves and TIMEOUT = 20.
//   Each slave is a behavioural responder with a programmable ack latency,
//   counted in strobe cycles (0 means it never acks), and fixed read data.
//   Every transaction that should end in an ack pushes its expected err flag
//   and data to a queue. A negedge monitor pops the queue on each wb_ack_o.
module tb_wbdispatch;

    logic        clk;
    logic        rst;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [15:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [6:0]  s_stb_o;
    logic [6:0]  s_cyc_o;
    logic        s_we_o;
    logic [7:0]  s_adr_o;
    logic [7:0]  s_dat_o;
    logic [55:0] s_dat_i;
    logic [6:0]  s_ack_i;

    typedef struct packed {
        logic       err;
        logic [7:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   rsp_lat[7];
    int   rsp_cnt[7];
    logic [6:0] spurious;

    wbdispatch #(
        .NUM_SLAVES(7),
        .ADDR_W(16),
        .DATA_W(8),
        .SEL_W(8),
        .TIMEOUT(20),
        .ERR_DATA(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o),
        .s_stb_o(s_stb_o),
        .s_cyc_o(s_cyc_o),
        .s_we_o(s_we_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setSlave(input int k, input int lat, input logic [7:0] dat);
        rsp_lat[k] = lat;
        s_dat_i[k*8 +: 8] = dat;
    endtask

    // Slave responders: ack in strobe cycle number rsp_lat[k] (1 = first).
    initial begin
        s_ack_i = '0;
        for (int k = 0; k < 7; k++) rsp_cnt[k] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 7; k++) begin
                if (s_stb_o[k]) rsp_cnt[k]++;
                else rsp_cnt[k] = 0;
                s_ack_i[k] = (s_stb_o[k] && rsp_cnt[k] == rsp_lat[k]) || spurious[k];
            end
        end
    end

    // Response monitor: every ack must match the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("stb_onehot0", $onehot0(s_stb_o), 1);
                if (wb_ack_o) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_ack", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("resp_err", wb_err_o, e.err);
                        checkOutput("resp_dat", wb_dat_o, e.dat);
                    end
                end
            end
        end
    end

    // Drives one master request, starting 1 time unit after a clock edge. It
    // returns the edge count until the ack, the slave-side activity it saw, and
    // drops cyc/stb one edge after the ack (stb held high through the ack cycle).
    task automatic applyStimulus(input logic we, input logic [15:0] adr, input logic [7:0] dat,
                                 input int max_cycles, output logic got_ack, output int ack_lat,
                                 output int stb_cycles, output logic [6:0] stb_seen,
                                 output logic [6:0] cyc_seen, output logic [7:0] adr_seen,
                                 output logic we_seen, output logic [7:0] dat_seen);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        got_ack = 1'b0;
        ack_lat = 0;
        stb_cycles = 0;
        stb_seen = '0;
        cyc_seen = '0;
        adr_seen = '0;
        we_seen = 1'b0;
        dat_seen = '0;
        for (int c = 1; c <= max_cycles && !got_ack; c++) begin
            @(posedge clk);
            #1;
            cyc_seen = cyc_seen | s_cyc_o;
            if (s_stb_o != '0) begin
                stb_cycles++;
                stb_seen = stb_seen | s_stb_o;
                adr_seen = s_adr_o;
                we_seen  = s_we_o;
                dat_seen = s_dat_o;
            end
            if (wb_ack_o) begin
                got_ack = 1'b1;
                ack_lat = c;
            end
        end
        if (got_ack) begin
            @(posedge clk);
            #1;
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
    endtask

    task automatic runTxn(input string tag, input logic we, input logic [15:0] adr,
                          input logic [7:0] dat, input logic exp_err, input logic [7:0] exp_dat,
                          input int exp_lat, input logic [6:0] exp_stb, input int exp_stb_cyc);
        logic got;
        int lat;
        int sc;
        logic [6:0] ss;
        logic [6:0] cs;
        logic [7:0] as;
        logic ws;
        logic [7:0] ds;
        sb.push_back('{err: exp_err, dat: exp_dat});
        applyStimulus(we, adr, dat, 40, got, lat, sc, ss, cs, as, ws, ds);
        checkOutput({tag, "_acked"}, got, 1);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_stb"}, ss, exp_stb);
        checkOutput({tag, "_cyc"}, cs, exp_stb);
        checkOutput({tag, "_stb_cycles"}, sc, exp_stb_cyc);
        if (exp_stb != '0) begin
            checkOutput({tag, "_s_adr"}, as, adr[7:0]);
            checkOutput({tag, "_s_we"}, ws, we);
            checkOutput({tag, "_s_dat"}, ds, dat);
        end
        if (got) begin
            checkOutput({tag, "_ack_pulse"}, wb_ack_o, 0);
        end else begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic got;
        int lat;
        int sc;
        logic [6:0] ss;
        logic [6:0] cs;
        logic [7:0] as;
        logic ws;
        logic [7:0] ds;

        n_vec = 0;
        n_err = 0;
        spurious = '0;
        s_dat_i = '0;
        for (int k = 0; k < 7; k++) rsp_lat[k] = 0;
        rst = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;

        // Reset values
        #2;
        checkOutput("rst_ack", wb_ack_o, 0);
        checkOutput("rst_err", wb_err_o, 0);
        checkOutput("rst_dat", wb_dat_o, 0);
        checkOutput("rst_stb", s_stb_o, 0);
        checkOutput("rst_cyc", s_cyc_o, 0);
        checkOutput("rst_s_we", s_we_o, 0);
        checkOutput("rst_s_adr", s_adr_o, 0);
        checkOutput("rst_s_dat", s_dat_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Slave 2 read: ack in 4th strobe cycle, master ack one edge later
        setSlave(2, 4, 8'h5A);
        runTxn("rd_s2", 1'b0, 16'h0203, 8'h00, 1'b0, 8'h5A, 5, 7'b0000100, 4);

        // Slave 6 write: read data is still captured
        setSlave(6, 2, 8'h3C);
        runTxn("wr_s6", 1'b1, 16'h0611, 8'hC3, 1'b0, 8'h3C, 3, 7'b1000000, 2);

        // Unmapped indices: error response at T+1, no slave strobed
        runTxn("unmap9", 1'b0, 16'h0900, 8'h00, 1'b1, 8'hFF, 1, 7'b0000000, 0);
        runTxn("unmap7", 1'b1, 16'h07AA, 8'h12, 1'b1, 8'hFF, 1, 7'b0000000, 0);
        runTxn("unmapFF", 1'b0, 16'hFF00, 8'h00, 1'b1, 8'hFF, 1, 7'b0000000, 0);

        // Slave 0 with the fastest possible ack
        setSlave(0, 1, 8'hA5);
        runTxn("rd_s0", 1'b0, 16'h00FE, 8'h00, 1'b0, 8'hA5, 2, 7'b0000001, 1);

        // An ack from a slave that is not addressed must be ignored
        setSlave(2, 4, 8'h81);
        spurious = 7'b0001000;
        runTxn("spur_s3", 1'b0, 16'h0244, 8'h00, 1'b0, 8'h81, 5, 7'b0000100, 4);
        spurious = '0;
        @(posedge clk);
        #1;

        // Slave 4 never acks
        setSlave(4, 0, 8'h44);
`ifdef WBDISPATCH_TIMEOUT_EN
        runTxn("timeout", 1'b0, 16'h0400, 8'h00, 1'b1, 8'hFF, 21, 7'b0010000, 20);
`else
        applyStimulus(1'b0, 16'h0400, 8'h00, 200, got, lat, sc, ss, cs, as, ws, ds);
        checkOutput("hang_no_ack", got, 0);
        checkOutput("hang_stb_cycles", sc, 200);
        checkOutput("hang_stb", s_stb_o, 7'b0010000);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hang_abort_stb", s_stb_o, 0);
        @(posedge clk);
        #1;
`endif

        // Abort: cyc dropped in the cycle in which slave 1 acks, so the abort wins
        setSlave(1, 3, 8'h11);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 16'h0105;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("abort_stb_before", s_stb_o, 7'b0000010);
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_stb_after", s_stb_o, 0);
        checkOutput("abort_no_ack", wb_ack_o, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("abort_idle_ack", wb_ack_o, 0);
        end

        // Master holds stb high through the ack cycle: exactly one transaction
        setSlave(1, 2, 8'h9C);
        runTxn("hold_s1", 1'b0, 16'h0120, 8'h00, 1'b0, 8'h9C, 3, 7'b0000010, 2);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("hold_no_reissue", s_stb_o, 0);
        end

        // Asynchronous reset in the middle of a transaction
        setSlave(5, 0, 8'h77);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 16'h0533;
        wb_dat_i = 8'h66;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_stb_before", s_stb_o, 7'b0100000);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_stb", s_stb_o, 0);
        checkOutput("midrst_cyc", s_cyc_o, 0);
        checkOutput("midrst_s_we", s_we_o, 0);
        checkOutput("midrst_ack", wb_ack_o, 0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Normal operation after the reset
        setSlave(3, 3, 8'hE7);
        runTxn("rd_s3", 1'b0, 16'h03C0, 8'h00, 1'b0, 8'hE7, 4, 7'b0001000, 3);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
